score_controller: RTL and testbench
===================================

Name: score_controller

Overview:
- Game-level score sequencer feeding the two-digit score renderer (score 0..15) and the VGA overlay gating.
- Collects hit and miss events from the game logic and commits score changes only at frame boundaries, so a digit never changes mid-frame.
- Runs the IDLE/PLAY/WIN/LOSE game state machine and blinks the score display on a win.

Parameters:
- MAX_SCORE, 15: terminal score. Score saturates here and reaching it means a win. Must be at most 15, the renderer limit.
- MAX_MISSES, 3: number of misses that ends the game.
- BLINK_FRAMES, 15: number of frames per blink half-period in WIN.
- PEND_W, 3: width of the pending-hit accumulator.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse: start or restart the game
- hit_event  in  1  single-cycle pulse: target hit, +1 point
- miss_event  in  1  single-cycle pulse: target missed
- frame_tick  in  1  single-cycle pulse at start of vertical blanking
- score  out  8  committed score; upper bits are always 0
- score_visible  out  1  gates score pixels onto the display
- misses  out  2  current miss count
- playing  out  1  high in PLAY
- win  out  1  high in WIN
- game_over  out  1  high in LOSE

Behaviour:
- Reset (asynchronous, takes effect immediately) sets:
  - state = IDLE
  - score = 0, pending = 0, misses = 0, blink counter = 0
  - score_visible = 1
  - playing = 0, win = 0, game_over = 0
- All outputs are registered. Status flags decode the state register directly.
- IDLE:
  - score = 0, visible = 1.
  - hit_event, miss_event and frame_tick are ignored.
  - start goes to PLAY on the next cycle; score, pending, misses and blink counter are cleared.
- PLAY, hit handling:
  - hit_event adds 1 to pending.
  - pending saturates at 2^PEND_W − 1; further hits are dropped.
- PLAY, frame_tick commit:
  - score <= min(score + pending, MAX_SCORE). Arithmetic is 9-bit, then clamped.
  - score is visible on the output 1 cycle after frame_tick.
  - pending is cleared on the commit.
  - If hit_event and frame_tick arrive in the same cycle, pending becomes 1: the new hit goes into the next frame, not the current commit.
- PLAY, miss handling:
  - miss_event increments misses immediately; it does not wait for a frame.
- PLAY, exits:
  - If misses + miss_event reaches MAX_MISSES, go to LOSE. Pending hits are discarded and score is frozen.
  - If the commit reaches MAX_SCORE, go to WIN.
  - If both happen in the same cycle, LOSE wins priority; score still commits.
- PLAY, restart: start clears score, pending and misses and stays in PLAY. start takes priority over any same-cycle events.
- WIN:
  - win = 1; score is held.
  - The blink counter counts frame_ticks. When it reaches BLINK_FRAMES, score_visible toggles and the counter resets to 0.
  - The first toggle happens on the BLINK_FRAMES-th frame_tick after entering WIN.
  - Events are ignored.
  - start goes to PLAY (clearing as from IDLE) with score_visible = 1.
- LOSE:
  - game_over = 1; score held; score_visible steady at 1.
  - Events are ignored.
  - start goes to PLAY (clearing as from IDLE).
- Reset asserted mid-PLAY or mid-WIN returns to IDLE with all values at their reset state on the same edge; there is no partial commit.
- Encoding: 2-bit state register. Unreachable encodings go to IDLE.

Test Plan:
- Reset, then start; 3 hit_event pulses; one frame_tick → score stays 0 until the cycle after the tick, then reads 3; playing = 1.
- Issue hit_event and frame_tick in the same cycle while pending = 2 → score += 2; the next frame_tick adds 1 more.
- Score 13, 5 hits, then frame_tick → score = 15; win = 1 next cycle. Then 15 frame_ticks → score_visible = 0; 15 more → score_visible = 1.
- Issue 10 hits in one frame → pending saturates at 7; score increases by exactly 7 at the tick.
- At score 14 with misses = 2, apply a miss_event plus a frame_tick with pending = 1 in the same cycle → score = 15, game_over = 1, win = 0.
- Assert reset asynchronously mid-PLAY at score 9, misses 1 → outputs become 0/0 immediately with visible = 1 and playing = 0. A hit_event before start leaves score at 0.

Source files
------------

// File: rtl/score_controller.sv
// Score sequencer: gathers hits per frame, commits on frame_tick, and runs the
// IDLE/PLAY/WIN/LOSE game flow with a blinking score display on a win.
module score_controller #(
  parameter int unsigned MAX_SCORE    = 15,
  parameter int unsigned MAX_MISSES   = 3,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter int unsigned PEND_W       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit_event,
  input  logic       miss_event,
  input  logic       frame_tick,
  output logic [7:0] score,
  output logic       score_visible,
  output logic [1:0] misses,
  output logic       playing,
  output logic       win,
  output logic       game_over
);

  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        score_q, score_d;
  logic [PEND_W-1:0] pend_q,  pend_d;
  logic [1:0]        miss_q,  miss_d;
  logic [BW-1:0]     blink_q, blink_d;
  logic              vis_q,   vis_d;

  logic [8:0]        sum;
  logic [2:0]        miss_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      pend_q  <= '0;
      miss_q  <= '0;
      blink_q <= '0;
      vis_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      pend_q  <= pend_d;
      miss_q  <= miss_d;
      blink_q <= blink_d;
      vis_q   <= vis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    pend_d   = pend_q;
    miss_d   = miss_q;
    blink_d  = blink_q;
    vis_d    = vis_q;
    sum      = 9'(score_q) + 9'(pend_q);
    miss_sum = {1'b0, miss_q} + {2'b00, miss_event};

    if (start) begin
      // start from any non-reset state restarts PLAY and beats same-cycle events
      state_d = PLAY;
      score_d = '0;
      pend_d  = '0;
      miss_d  = '0;
      blink_d = '0;
      vis_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        PLAY: begin
          if (frame_tick) begin
            score_d = (sum >= 9'(MAX_SCORE)) ? 4'(MAX_SCORE) : sum[3:0];
            pend_d  = PEND_W'(hit_event);
          end else if (hit_event && (pend_q != '1)) begin
            pend_d = pend_q + PEND_W'(1);
          end
          if (miss_event) begin
            miss_d = miss_q + 2'd1;
          end
          if (miss_sum >= 3'(MAX_MISSES)) begin
            state_d = LOSE;
            pend_d  = '0;
          end else if (frame_tick && (sum >= 9'(MAX_SCORE))) begin
            state_d = WIN;
            pend_d  = '0;
            blink_d = '0;
          end
        end
        WIN: begin
          if (frame_tick) begin
            if (blink_q == BW'(BLINK_FRAMES - 1)) begin
              blink_d = '0;
              vis_d   = ~vis_q;
            end else begin
              blink_d = blink_q + BW'(1);
            end
          end
        end
        LOSE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign score         = {4'b0000, score_q};
  assign score_visible = vis_q;
  assign misses        = miss_q;
  assign playing       = (state_q == PLAY);
  assign win           = (state_q == WIN);
  assign game_over     = (state_q == LOSE);

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller: a rule-level game model checked every
// negative edge, plus literal checkpoints that pin the model.
module tb_score_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       hit_event = 1'b0;
  logic       miss_event = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] score;
  logic       score_visible;
  logic [1:0] misses;
  logic       playing;
  logic       win;
  logic       game_over;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  score_controller #(
    .MAX_SCORE   (15),
    .MAX_MISSES  (3),
    .BLINK_FRAMES(15),
    .PEND_W      (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .hit_event    (hit_event),
    .miss_event   (miss_event),
    .frame_tick   (frame_tick),
    .score        (score),
    .score_visible(score_visible),
    .misses       (misses),
    .playing      (playing),
    .win          (win),
    .game_over    (game_over)
  );

  // Game model: mode flags, integer score/pending/misses, ticks seen since winning
  int m_score = 0, m_pend = 0, m_miss = 0, m_blinks = 0;
  bit m_play = 0, m_win = 0, m_lose = 0;
  int ns;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_score = 0; m_pend = 0; m_miss = 0; m_blinks = 0;
      m_play = 0; m_win = 0; m_lose = 0;
    end else if (start) begin
      m_score = 0; m_pend = 0; m_miss = 0; m_blinks = 0;
      m_play = 1; m_win = 0; m_lose = 0;
    end else if (m_play) begin
      ns = frame_tick ? ((m_score + m_pend > 15) ? 15 : m_score + m_pend) : m_score;
      if (frame_tick) m_pend = hit_event ? 1 : 0;
      else if (hit_event && m_pend < 7) m_pend = m_pend + 1;
      m_miss = m_miss + (miss_event ? 1 : 0);
      m_score = ns;
      if (m_miss >= 3) begin
        m_play = 0; m_lose = 1; m_pend = 0;
      end else if (frame_tick && ns == 15) begin
        m_play = 0; m_win = 1; m_pend = 0; m_blinks = 0;
      end
    end else if (m_win && frame_tick) begin
      m_blinks = m_blinks + 1;
    end
  end

  function automatic bit model_vis();
    return ((m_blinks / 15) % 2) == 0;
  endfunction

  always @(negedge clk) begin
    logic [13:0] exp_v, got_v;
    exp_v = {8'(m_score), model_vis(), 2'(m_miss), m_play, m_win, m_lose};
    got_v = {score, score_visible, misses, playing, win, game_over};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t got score=%0d vis=%b misses=%0d play=%b win=%b over=%b required score=%0d vis=%b misses=%0d play=%b win=%b over=%b",
               $time, score, score_visible, misses, playing, win, game_over,
               m_score, model_vis(), m_miss, m_play, m_win, m_lose);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input bit s, input bit h, input bit m, input bit t);
    start = s; hit_event = h; miss_event = m; frame_tick = t;
    @(posedge clk);
    #1;
    start = 0; hit_event = 0; miss_event = 0; frame_tick = 0;
  endtask

  task automatic hits(input int n);
    repeat (n) cyc(0, 1, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(0, 0, 0, 1);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_score", score, 0);
    chk("reset_visible", score_visible, 1);
    chk("reset_playing", playing, 0);
    reset = 1'b0;

    hits(1); ticks(1);
    chk("idle_ignores_hit", score, 0);

    cyc(1, 0, 0, 0);
    chk("start_playing", playing, 1);
    hits(3);
    chk("score_before_tick", score, 0);
    ticks(1);
    chk("score_after_tick", score, 3);

    hits(2);
    cyc(0, 1, 0, 1);
    chk("tick_with_hit", score, 5);
    ticks(1);
    chk("carried_hit", score, 6);

    hits(10); ticks(1);
    chk("pend_saturate", score, 13);

    hits(5); ticks(1);
    chk("clamp_score", score, 15);
    chk("win_flag", win, 1);
    chk("win_playing", playing, 0);

    ticks(14);
    chk("blink_before_15", score_visible, 1);
    ticks(1);
    chk("blink_first_toggle", score_visible, 0);
    cyc(0, 1, 1, 0);
    chk("win_ignores_miss", misses, 0);
    ticks(14);
    chk("blink_hold", score_visible, 0);
    ticks(1);
    chk("blink_second_toggle", score_visible, 1);

    cyc(1, 0, 0, 0);
    chk("restart_from_win", score, 0);
    hits(7); ticks(1); hits(7); ticks(1);
    chk("score_14", score, 14);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    chk("misses_2", misses, 2);
    hits(1);
    cyc(0, 0, 1, 1);
    chk("lose_score", score, 15);
    chk("lose_over", game_over, 1);
    chk("lose_not_win", win, 0);
    chk("lose_misses", misses, 3);
    hits(2); ticks(1);
    chk("lose_frozen", score, 15);

    cyc(1, 0, 0, 0);
    chk("restart_from_lose", playing, 1);
    hits(3);
    cyc(1, 1, 1, 1);
    chk("start_priority_score", score, 0);
    chk("start_priority_miss", misses, 0);
    ticks(1);
    chk("start_clears_pend", score, 0);

    hits(7); ticks(1); hits(2); ticks(1);
    cyc(0, 0, 1, 0);
    chk("pre_reset_score", score, 9);
    chk("pre_reset_misses", misses, 1);
    hits(2);
    #2 reset = 1'b1;
    #1;
    chk("async_score", score, 0);
    chk("async_misses", misses, 0);
    chk("async_visible", score_visible, 1);
    chk("async_playing", playing, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    hits(1); ticks(1);
    chk("post_reset_idle", score, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
